traffic_phase_controller: RTL and testbench

TRAFFIC_PHASE_CONTROLLER -- requirements
Module: traffic_phase_controller

---
 rtl/traffic_phase_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_traffic_phase_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: multi-phase traffic signal sequencer.
// Runs GREEN -> YELLOW -> ALLRED per phase, either on fixed timing or
// holding green until another phase has pending demand (actuated mode).
// Optional flashing-yellow override is compiled in when TLC_FLASH_EN is defined.
module traffic_phase_controller #(
   parameter int unsigned NUM_PHASES = 4,
   parameter int unsigned GREEN_T    = 10,
   parameter int unsigned YELLOW_T   = 3,
   parameter int unsigned ALLRED_T   = 2,
   parameter int unsigned FLASH_T    = 8,
   parameter int unsigned CNT_W      = 17
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          actuated,
   input  logic [NUM_PHASES-1:0]         req,
`ifdef TLC_FLASH_EN
   input  logic                          flash,
`endif
   output logic [3*NUM_PHASES-1:0]       lights,
   output logic [$clog2(NUM_PHASES)-1:0] phase,
   output logic [1:0]                    interval,
   output logic                          phase_start
);

   localparam int unsigned PH_W  = $clog2(NUM_PHASES);
   localparam int unsigned T_MAX = (32'd1 << CNT_W) - 32'd1;

   localparam logic [PH_W-1:0]  LAST_PH = PH_W'(NUM_PHASES - 1);
   localparam logic [CNT_W-1:0] G_END   = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] Y_END   = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] A_END   = CNT_W'(ALLRED_T - 1);

   localparam logic [2:0] L_RED = 3'b100;
   localparam logic [2:0] L_YEL = 3'b010;
   localparam logic [2:0] L_GRN = 3'b001;

`ifdef TLC_FLASH_EN
   localparam logic [CNT_W-1:0] F_END  = CNT_W'(FLASH_T - 1);
   localparam logic [2:0]       L_DARK = 3'b000;
`endif

   // Elaboration-time parameter legality checks
   if (NUM_PHASES < 2 || NUM_PHASES > 8) begin : g_bad_num_phases
      $error("traffic_phase_controller: NUM_PHASES must be 2..8");
   end
   if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
      $error("traffic_phase_controller: CNT_W must be 1..31");
   end
   if (GREEN_T < 1 || GREEN_T > T_MAX || YELLOW_T < 1 || YELLOW_T > T_MAX ||
       ALLRED_T < 1 || ALLRED_T > T_MAX || FLASH_T < 1 || FLASH_T > T_MAX) begin : g_bad_timing
      $error("traffic_phase_controller: interval durations must be 1..2^CNT_W-1");
   end

   // Encoding doubles as the interval output code
   typedef enum logic [1:0] {
      ST_GREEN  = 2'b00,
      ST_YELLOW = 2'b01,
      ST_ALLRED = 2'b10
`ifdef TLC_FLASH_EN
      ,
      ST_FLASH  = 2'b11
`endif
   } state_t;

   state_t                  state_q, state_n;
   logic [CNT_W-1:0]        timer_q, timer_n;
   logic [PH_W-1:0]         phase_q, phase_n;
   logic [NUM_PHASES-1:0]   pending_q, pending_n;
   logic                    hold_q, hold_n;
   logic                    restart;
`ifdef TLC_FLASH_EN
   logic                    flash_on_q, flash_on_n;
`endif

   logic [NUM_PHASES-1:0]   ph_oh;
   logic [NUM_PHASES-1:0]   eff_req;
   logic [NUM_PHASES-1:0]   other_req;
   logic [PH_W-1:0]         inc_ph;
   logic [PH_W-1:0]         pick_ph;
   logic [PH_W-1:0]         scan;
   logic                    found;

   logic [3*NUM_PHASES-1:0] lights_n;
   logic                    phase_start_n;

   assign phase    = phase_q;
   assign interval = state_q;

   // Demand bookkeeping and next-phase selection (pure function of current state)
   always_comb begin
      ph_oh          = '0;
      ph_oh[phase_q] = 1'b1;
      // A request for the phase already showing green is dropped
      eff_req   = pending_q | (req & ~((state_q == ST_GREEN) ? ph_oh : '0));
      other_req = eff_req & ~ph_oh;
      inc_ph    = (phase_q == LAST_PH) ? '0 : phase_q + 1'b1;
      pick_ph   = inc_ph;
      found     = 1'b0;
      scan      = phase_q;
      // Upward search from phase+1 with wrap; current phase is checked last
      for (int k = 0; k < NUM_PHASES; k++) begin
         scan = (scan == LAST_PH) ? '0 : scan + 1'b1;
         if (!found && eff_req[scan]) begin
            pick_ph = scan;
            found   = 1'b1;
         end
      end
   end

   // Next-state, phase, demand and timer logic
   always_comb begin
      state_n   = state_q;
      phase_n   = phase_q;
      pending_n = eff_req;
      hold_n    = hold_q;
      restart   = 1'b0;
      timer_n   = timer_q;
`ifdef TLC_FLASH_EN
      flash_on_n = flash_on_q;
`endif

      case (state_q)
         ST_GREEN: begin
            if (hold_q) begin
               // Actuated hold: leave as soon as any other phase wants service
               if (|other_req) state_n = ST_YELLOW;
            end else if (timer_q == G_END) begin
               // Mode is sampled here only; the hold flag carries the decision
               if (!actuated || (|other_req)) state_n = ST_YELLOW;
               else                           hold_n  = 1'b1;
            end
         end
         ST_YELLOW: begin
            if (timer_q == Y_END) state_n = ST_ALLRED;
         end
         ST_ALLRED: begin
            if (timer_q == A_END) begin
               state_n            = ST_GREEN;
               phase_n            = actuated ? pick_ph : inc_ph;
               pending_n[phase_n] = 1'b0;
            end
         end
`ifdef TLC_FLASH_EN
         ST_FLASH: begin
            pending_n = '0;
            if (timer_q == F_END) begin
               restart    = 1'b1;
               flash_on_n = ~flash_on_q;
            end
         end
`endif
         default: begin
            state_n = ST_ALLRED;
         end
      endcase

`ifdef TLC_FLASH_EN
      // Flash overrides everything; release always restarts from the last phase
      if (flash) begin
         pending_n = '0;
         if (state_q != ST_FLASH) begin
            state_n    = ST_FLASH;
            flash_on_n = 1'b1;
         end
      end else if (state_q == ST_FLASH) begin
         state_n = ST_ALLRED;
         phase_n = LAST_PH;
      end
`endif

      if (state_n != ST_GREEN) hold_n = 1'b0;

      // Timer clears on any state change and saturates rather than wrapping
      if ((state_n != state_q) || restart) timer_n = '0;
      else if (&timer_q)                   timer_n = timer_q;
      else                                 timer_n = timer_q + 1'b1;
   end

   // Output decode from next-state values so outputs move with the state register
   always_comb begin
      lights_n = '0;
      for (int p = 0; p < NUM_PHASES; p++) begin
         lights_n[3*p +: 3] = L_RED;
         case (state_n)
            ST_GREEN:  if (phase_n == PH_W'(p)) lights_n[3*p +: 3] = L_GRN;
            ST_YELLOW: if (phase_n == PH_W'(p)) lights_n[3*p +: 3] = L_YEL;
`ifdef TLC_FLASH_EN
            ST_FLASH:  lights_n[3*p +: 3] = flash_on_n ? L_YEL : L_DARK;
`endif
            default:   lights_n[3*p +: 3] = L_RED;
         endcase
      end
      phase_start_n = (state_n == ST_GREEN) && (state_q != ST_GREEN);
   end

   // State, timer, demand and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ALLRED;
         phase_q     <= LAST_PH;
         timer_q     <= '0;
         pending_q   <= '0;
         hold_q      <= 1'b0;
         lights      <= {NUM_PHASES{L_RED}};
         phase_start <= 1'b0;
`ifdef TLC_FLASH_EN
         flash_on_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_n;
         phase_q     <= phase_n;
         timer_q     <= timer_n;
         pending_q   <= pending_n;
         hold_q      <= hold_n;
         lights      <= lights_n;
         phase_start <= phase_start_n;
`ifdef TLC_FLASH_EN
         flash_on_q  <= flash_on_n;
`endif
      end
   end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench for traffic_phase_controller (3 phases, G4/Y2/AR1/F3).
// Stimulus pushes hand-derived per-cycle expectations; a negedge monitor
// pops and compares them, and checks safety invariants during random traffic.
module tb_traffic_phase_controller;

   localparam int unsigned NP = 3;
   localparam int unsigned PW = $clog2(NP);

   localparam logic [1:0] IV_G = 2'b00;
   localparam logic [1:0] IV_Y = 2'b01;
   localparam logic [1:0] IV_A = 2'b10;
   localparam logic [1:0] IV_F = 2'b11;

   typedef struct packed {
      logic [3*NP-1:0] lights;
      logic [PW-1:0]   phase;
      logic [1:0]      interval;
      logic            phase_start;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            actuated;
   logic [NP-1:0]   req;
`ifdef TLC_FLASH_EN
   logic            flash;
`endif
   logic [3*NP-1:0] lights;
   logic [PW-1:0]   phase;
   logic [1:0]      interval;
   logic            phase_start;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   seq_no   = 0;
   int   nonred;
   logic [2:0] cur;
   bit   rand_mode = 1'b0;

   traffic_phase_controller #(
      .NUM_PHASES(NP), .GREEN_T(4), .YELLOW_T(2), .ALLRED_T(1), .FLASH_T(3), .CNT_W(5)
   ) dut (
      .clk(clk), .rst(rst), .actuated(actuated), .req(req),
`ifdef TLC_FLASH_EN
      .flash(flash),
`endif
      .lights(lights), .phase(phase), .interval(interval), .phase_start(phase_start)
   );

   always #5 clk = ~clk;

   // Reference light pattern derived from interval and phase
   function automatic logic [3*NP-1:0] exp_lights(input logic [1:0] iv, input int ph, input bit on);
      logic [3*NP-1:0] l;
      l = '0;
      for (int p = 0; p < NP; p++) begin
         case (iv)
            IV_G:    l[3*p +: 3] = (p == ph) ? 3'b001 : 3'b100;
            IV_Y:    l[3*p +: 3] = (p == ph) ? 3'b010 : 3'b100;
            IV_A:    l[3*p +: 3] = 3'b100;
            default: l[3*p +: 3] = on ? 3'b010 : 3'b000;
         endcase
      end
      return l;
   endfunction

   // Advance one clock and queue the outputs expected for the new cycle
   task automatic step(input logic [1:0] iv, input int ph, input bit ps, input bit on);
      exp_t e;
      @(posedge clk);
      #1;
      e.lights      = exp_lights(iv, ph, on);
      e.phase       = PW'(ph);
      e.interval    = iv;
      e.phase_start = ps;
      exp_q.push_back(e);
   endtask

   task automatic seg(input logic [1:0] iv, input int ph, input int n, input bit ps_first);
      for (int i = 0; i < n; i++) step(iv, ph, ps_first && (i == 0), 1'b1);
   endtask

   // Monitor: scoreboard compare plus invariant checks in random mode
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (lights !== mon_e.lights || phase !== mon_e.phase ||
             interval !== mon_e.interval || phase_start !== mon_e.phase_start) begin
            failures++;
            $display("FAIL out#%0d: got lights=%b phase=%0d interval=%b start=%b, need lights=%b phase=%0d interval=%b start=%b",
                     seq_no, lights, phase, interval, phase_start,
                     mon_e.lights, mon_e.phase, mon_e.interval, mon_e.phase_start);
         end
         seq_no++;
      end
      if (rand_mode) begin
         nonred = 0;
         for (int p = 0; p < NP; p++) if (lights[3*p +: 3] != 3'b100) nonred++;
         cur = (int'(phase) < NP) ? lights[3*int'(phase) +: 3] : 3'bxxx;
         checks++;
         if (interval === IV_F || int'(phase) >= NP ||
             (interval === IV_A && nonred != 0) ||
             (interval === IV_G && (nonred != 1 || cur !== 3'b001)) ||
             (interval === IV_Y && (nonred != 1 || cur !== 3'b010))) begin
            failures++;
            $display("FAIL invariant: interval=%b phase=%0d lights=%b nonred=%0d",
                     interval, phase, lights, nonred);
         end
      end
   end

   // Hard bound on simulation time
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      actuated = 1'b0;
      req      = '0;
`ifdef TLC_FLASH_EN
      flash    = 1'b0;
`endif

      // Fixed mode from reset: one ALLRED cycle then 21-cycle rotation
      step(IV_A, 2, 1'b0, 1'b1);
      rst = 1'b0;
      for (int r = 0; r < 3; r++) begin
         seg(IV_G, r, 4, 1'b1);
         seg(IV_Y, r, 2, 1'b0);
         seg(IV_A, r, 1, 1'b0);
      end
      seg(IV_G, 0, 2, 1'b1);

      // Reset on the second yellow cycle of phase 1
      rst = 1'b1;
      step(IV_A, 2, 1'b0, 1'b1);
      rst = 1'b0;
      seg(IV_G, 0, 4, 1'b1);
      seg(IV_Y, 0, 2, 1'b0);
      seg(IV_A, 0, 1, 1'b0);
      seg(IV_G, 1, 4, 1'b1);
      seg(IV_Y, 1, 2, 1'b0);
      rst = 1'b1;
      step(IV_A, 2, 1'b0, 1'b1);
      rst = 1'b0;
      seg(IV_G, 0, 2, 1'b1);

      // Actuated: green held without demand, own-phase requests ignored
      actuated = 1'b1;
      rst = 1'b1;
      step(IV_A, 2, 1'b0, 1'b1);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step(IV_G, 0, i == 0, 1'b1);
         if (i == 1)  req = 3'b001;
         if (i == 2)  req = 3'b000;
         if (i == 49) req = 3'b100;
      end
      step(IV_Y, 0, 1'b0, 1'b1);
      req = '0;
      seg(IV_Y, 0, 1, 1'b0);
      seg(IV_A, 0, 1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(IV_G, 2, i == 0, 1'b1);
         if (i == 10) req = 3'b100;
         if (i == 11) req = 3'b000;
         if (i == 19) req = 3'b010;
      end
      step(IV_Y, 2, 1'b0, 1'b1);
      req = '0;
      seg(IV_Y, 2, 1, 1'b0);
      seg(IV_A, 2, 1, 1'b0);
      // Mode change mid-hold has no effect; fixed mode takes over at ALLRED end
      for (int i = 0; i < 20; i++) begin
         step(IV_G, 1, i == 0, 1'b1);
         if (i == 8)  actuated = 1'b0;
         if (i == 19) req = 3'b001;
      end
      step(IV_Y, 1, 1'b0, 1'b1);
      req = '0;
      seg(IV_Y, 1, 1, 1'b0);
      seg(IV_A, 1, 1, 1'b0);
      seg(IV_G, 2, 4, 1'b1);
      seg(IV_Y, 2, 2, 1'b0);
      seg(IV_A, 2, 1, 1'b0);
      seg(IV_G, 0, 2, 1'b1);

`ifdef TLC_FLASH_EN
      // Flash entry from green, blink pattern, and release into ALLRED
      rst = 1'b1;
      step(IV_A, 2, 1'b0, 1'b1);
      rst = 1'b0;
      seg(IV_G, 0, 2, 1'b1);
      flash = 1'b1;
      for (int h = 0; h < 3; h++)
         for (int i = 0; i < 3; i++) step(IV_F, 0, 1'b0, (h % 2) == 0);
      flash = 1'b0;
      seg(IV_A, 2, 1, 1'b0);
      seg(IV_G, 0, 2, 1'b1);
`endif

      // Random traffic with invariant monitoring
      rst = 1'b1;
      step(IV_A, 2, 1'b0, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      rand_mode = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1;
         if ($urandom_range(0, 49) == 0) actuated = ~actuated;
         req = ($urandom_range(0, 5) == 0) ? NP'($urandom) : '0;
      end
      @(negedge clk);
      #1;
      rand_mode = 1'b0;
      req = '0;

      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left unchecked, need 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
